// File: rtl/npu_pkg.sv
// Shared NPU types, widths and arithmetic helpers; this slice holds the requantization stage's part.
package npu_pkg;

  localparam int REQ_ACC_WIDTH   = 32;
  localparam int REQ_MULT_WIDTH  = 16;
  localparam int REQ_SHIFT_WIDTH = 5;
  localparam int REQ_DATA_WIDTH  = 8;
  localparam int REQ_PROD_WIDTH  = REQ_ACC_WIDTH + REQ_MULT_WIDTH;
  localparam int REQ_SUM_WIDTH   = REQ_PROD_WIDTH + 2;

  localparam logic signed [REQ_SUM_WIDTH-1:0] REQ_SAT_MAX = REQ_SUM_WIDTH'(2**(REQ_DATA_WIDTH-1) - 1);
  localparam logic signed [REQ_SUM_WIDTH-1:0] REQ_SAT_MIN = ~REQ_SAT_MAX;

  typedef struct packed {
    logic signed [REQ_MULT_WIDTH-1:0] mult;
    logic        [REQ_SHIFT_WIDTH-1:0] shift;
    logic signed [REQ_DATA_WIDTH-1:0] zp;
  } requant_param_t;

  typedef enum logic [1:0] {TBL_EMPTY, TBL_LOADING, TBL_LOADED} tbl_state_t;

  // Arithmetic right shift that rounds halves toward +inf; one extra bit keeps the bias add exact.
  function automatic logic signed [REQ_PROD_WIDTH:0] round_shift(
    input logic signed [REQ_PROD_WIDTH-1:0] prod,
    input logic        [REQ_SHIFT_WIDTH-1:0] shift
  );
    logic signed [REQ_PROD_WIDTH:0] ext;
    logic signed [REQ_PROD_WIDTH:0] bias;
    ext  = {prod[REQ_PROD_WIDTH-1], prod};
    bias = (shift == '0) ? '0 : ({{REQ_PROD_WIDTH{1'b0}}, 1'b1} << (shift - 1'b1));
    return (ext + bias) >>> shift;
  endfunction

  function automatic logic signed [REQ_DATA_WIDTH-1:0] sat_to_int8(
    input logic signed [REQ_SUM_WIDTH-1:0] v
  );
    if (v > REQ_SAT_MAX) return REQ_SAT_MAX[REQ_DATA_WIDTH-1:0];
    if (v < REQ_SAT_MIN) return REQ_SAT_MIN[REQ_DATA_WIDTH-1:0];
    return v[REQ_DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/requant_param_table.sv
// Per-channel {mult, shift, zp} storage with the EMPTY/LOADING/LOADED load sequencer.
module requant_param_table
  import npu_pkg::*;
#(
  parameter int MAX_CHANNELS = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_params,
  input  logic [7:0]                   num_channels,
  input  logic                         param_valid,
  input  logic [REQ_MULT_WIDTH-1:0]    mult_in,
  input  logic [REQ_SHIFT_WIDTH-1:0]   shift_in,
  input  logic [REQ_DATA_WIDTH-1:0]    zp_in,
  input  logic [7:0]                   rd_idx,
  output requant_param_t               rd_param,
  output logic                         params_loaded
);

  tbl_state_t     state_q, state_d;
  logic [7:0]     idx_q, idx_d;
  logic [7:0]     last_idx;
  logic           wr_en;
  requant_param_t mem [MAX_CHANNELS];

  // num_channels==0 wraps to 255, so a 256-entry load needs no special case.
  assign last_idx = num_channels - 8'd1;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TBL_EMPTY;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: the table is deliberately not reset; its contents only matter once LOADED, and a reset would prevent RAM mapping.
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx_q] <= '{mult: mult_in, shift: shift_in, zp: zp_in};
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    unique case (state_q)
      TBL_LOADING: begin
        if (param_valid) begin
          wr_en = 1'b1;
          idx_d = idx_q + 8'd1;
          if (idx_q == last_idx) state_d = TBL_LOADED;
        end
      end
      default: ;
    endcase
    // A restart wins over a same-cycle word, which is dropped.
    if (load_params) begin
      state_d = TBL_LOADING;
      idx_d   = '0;
      wr_en   = 1'b0;
    end
  end

  assign rd_param      = mem[rd_idx];
  assign params_loaded = (state_q == TBL_LOADED);

endmodule

// File: rtl/requant_unit.sv
// Per-channel requantizer: y = sat(round((acc * mult) >> shift) + zp), 3-stage valid/ready pipeline.
module requant_unit
  import npu_pkg::*;
#(
  parameter int ACC_WIDTH    = REQ_ACC_WIDTH,
  parameter int DATA_WIDTH   = REQ_DATA_WIDTH,
  parameter int MULT_WIDTH   = REQ_MULT_WIDTH,
  parameter int SHIFT_WIDTH  = REQ_SHIFT_WIDTH,
  parameter int MAX_CHANNELS = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_params,
  input  logic [7:0]             num_channels,
  input  logic                   param_valid,
  input  logic [MULT_WIDTH-1:0]  mult_in,
  input  logic [SHIFT_WIDTH-1:0] shift_in,
  input  logic [DATA_WIDTH-1:0]  zp_in,
  output logic                   params_loaded,
  input  logic                   ch_restart,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [ACC_WIDTH-1:0]   s_acc,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic [7:0]             m_channel
);

  localparam int PROD_WIDTH = ACC_WIDTH + MULT_WIDTH;

  logic           adv, accept;
  logic [7:0]     chan_q;
  requant_param_t rd_param;

  logic                          v1_q, v2_q;
  logic signed [ACC_WIDTH-1:0]   acc1_q;
  requant_param_t                p1_q;
  logic [7:0]                    ch1_q, ch2_q;
  logic signed [PROD_WIDTH-1:0]  prod2_q;
  logic [SHIFT_WIDTH-1:0]        shift2_q;
  logic signed [DATA_WIDTH-1:0]  zp2_q;

  logic signed [REQ_PROD_WIDTH:0]  rounded;
  logic signed [REQ_SUM_WIDTH-1:0] biased;

  requant_param_table #(.MAX_CHANNELS(MAX_CHANNELS)) u_table (
    .clk           (clk),
    .rst           (rst),
    .load_params   (load_params),
    .num_channels  (num_channels),
    .param_valid   (param_valid),
    .mult_in       (mult_in),
    .shift_in      (shift_in),
    .zp_in         (zp_in),
    .rd_idx        (chan_q),
    .rd_param      (rd_param),
    .params_loaded (params_loaded)
  );

  assign adv     = !m_valid || m_ready;
  assign s_ready = params_loaded && adv;
  assign accept  = s_valid && s_ready;

  assign rounded = round_shift(prod2_q, shift2_q);
  assign biased  = REQ_SUM_WIDTH'(rounded) + REQ_SUM_WIDTH'(zp2_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      chan_q    <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_channel <= '0;
    end else begin
      if (ch_restart)
        chan_q <= '0;
      else if (accept)
        chan_q <= (chan_q == num_channels - 8'd1) ? 8'd0 : chan_q + 8'd1;
      if (adv) begin
        v1_q    <= accept;
        v2_q    <= v1_q;
        m_valid <= v2_q;
        if (v2_q) begin
          m_data    <= sat_to_int8(biased);
          m_channel <= ch2_q;
        end
      end
    end
  end

  // Datapath registers carry parameters with each beat, so a table reload never disturbs beats in flight.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc1_q <= $signed(s_acc);
      p1_q   <= rd_param;
      ch1_q  <= chan_q;
    end
    if (adv && v1_q) begin
      prod2_q  <= PROD_WIDTH'(acc1_q) * PROD_WIDTH'($signed(p1_q.mult));
      shift2_q <= p1_q.shift;
      zp2_q    <= p1_q.zp;
      ch2_q    <= ch1_q;
    end
  end

endmodule

// File: tb/tb_requant_unit.sv
// Directed and randomized-handshake bench for requant_unit with an independent integer reference model.
module tb_requant_unit;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_params = 1'b0;
  logic [7:0]        num_channels = '0;
  logic              param_valid = 1'b0;
  logic [15:0]       mult_in = '0;
  logic [4:0]        shift_in = '0;
  logic [7:0]        zp_in = '0;
  logic              params_loaded;
  logic              ch_restart = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [31:0]       s_acc = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic signed [7:0] m_data;
  logic [7:0]        m_channel;

  requant_unit dut (
    .clk           (clk),
    .rst           (rst),
    .load_params   (load_params),
    .num_channels  (num_channels),
    .param_valid   (param_valid),
    .mult_in       (mult_in),
    .shift_in      (shift_in),
    .zp_in         (zp_in),
    .params_loaded (params_loaded),
    .ch_restart    (ch_restart),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_acc         (s_acc),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_channel     (m_channel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int tbl_mult  [256];
  int tbl_shift [256];
  int tbl_zp    [256];

  int got_d  [16];
  int got_ch [16];

  int exp_plain_d  [7] = '{0, 10, 20, 0, 10, 20, 0};
  int exp_plain_ch [7] = '{0, 1, 2, 0, 1, 2, 0};
  int exp_rst_d    [7] = '{0, 10, 20, 0, 10, 0, 10};
  int exp_rst_ch   [7] = '{0, 1, 2, 0, 1, 0, 1};

  int dir_acc [5] = '{200, 201, -201, 1000, -1000};
  int dir_exp [5] = '{100, 101, -100, 127, -128};

  int exp_d_q  [$];
  int exp_ch_q [$];

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_requant(input longint acc, input int ch);
    longint prod, bias, r;
    prod = acc * longint'(tbl_mult[ch]);
    bias = (tbl_shift[ch] > 0) ? (longint'(1) <<< (tbl_shift[ch] - 1)) : 64'sd0;
    r    = ((prod + bias) >>> tbl_shift[ch]) + longint'(tbl_zp[ch]);
    if (r > 127)  return 127;
    if (r < -128) return -128;
    return int'(r);
  endfunction

  task automatic set_param(input int i, input int mult, input int shift, input int zp);
    tbl_mult[i]  = mult;
    tbl_shift[i] = shift;
    tbl_zp[i]    = zp;
  endtask

  task automatic load_table(input int n);
    @(negedge clk);
    load_params  = 1'b1;
    num_channels = 8'(n);
    @(negedge clk);
    load_params = 1'b0;
    for (int i = 0; i < n; i++) begin
      param_valid = 1'b1;
      mult_in     = 16'(tbl_mult[i]);
      shift_in    = 5'(tbl_shift[i]);
      zp_in       = 8'(tbl_zp[i]);
      @(negedge clk);
    end
    param_valid = 1'b0;
    #1 check("params_loaded_after_load", params_loaded, 1);
  endtask

  task automatic send_one(input string tag, input int acc, input int exp_d, input int exp_ch);
    int waited;
    int lat;
    @(negedge clk);
    ch_restart = 1'b0;
    m_ready    = 1'b1;
    s_valid    = 1'b1;
    s_acc      = acc;
    #1 waited = 0;
    while (!s_ready && waited < 20) begin
      @(negedge clk);
      #1 waited++;
    end
    check({tag, "_s_ready"}, s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0;
    lat = 1;
    #1;
    while (!m_valid && lat < 10) begin
      @(negedge clk);
      #1 lat++;
    end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_data"}, m_data, exp_d);
    check({tag, "_channel"}, m_channel, exp_ch);
  endtask

  task automatic stream(input int n, input int restart_at);
    int sent, got, cyc;
    @(negedge clk);
    ch_restart = 1'b1;
    s_valid    = 1'b0;
    m_ready    = 1'b1;
    sent = 0; got = 0; cyc = 0;
    while (got < n && cyc < 100) begin
      @(negedge clk);
      s_valid    = (sent < n);
      s_acc      = '0;
      ch_restart = (sent == restart_at) && (sent < n);
      #1;
      if (m_valid) begin
        got_d[got]  = m_data;
        got_ch[got] = m_channel;
        got++;
      end
      if (s_valid && s_ready) sent++;
      cyc++;
    end
    s_valid    = 1'b0;
    ch_restart = 1'b0;
    check("stream_count", got, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent, cyc, a, chan_m, exp0, exp1;
    bit prev_stall;
    int prev_d, prev_ch;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_channel", m_channel, 0);
    check("rst_params_loaded", params_loaded, 0);
    check("rst_s_ready", s_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    param_valid = 1'b1;
    @(negedge clk);
    param_valid = 1'b0;
    #1;
    check("empty_ignores_param_valid", params_loaded, 0);
    check("empty_s_ready", s_ready, 0);

    // Single channel, halving with rounding and saturation
    set_param(0, 16384, 15, 0);
    load_table(1);
    for (int i = 0; i < 5; i++) send_one($sformatf("half_%0d", dir_acc[i]), dir_acc[i], dir_exp[i], 0);

    set_param(0, 16384, 15, -5);
    load_table(1);
    send_one("zp_neg5", 201, 96, 0);

    set_param(0, 1, 0, 0);
    load_table(1);
    send_one("shift0", -7, -7, 0);

    // Three channels, channel sequencing and restart
    set_param(0, 1, 0, 0);
    set_param(1, 1, 0, 10);
    set_param(2, 1, 0, 20);
    load_table(3);
    stream(7, -1);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("plain_data_%0d", i), got_d[i], exp_plain_d[i]);
      check($sformatf("plain_ch_%0d", i), got_ch[i], exp_plain_ch[i]);
    end
    stream(7, 4);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("restart_data_%0d", i), got_d[i], exp_rst_d[i]);
      check($sformatf("restart_ch_%0d", i), got_ch[i], exp_rst_ch[i]);
    end

    // Random backpressure against the reference model
    for (int i = 0; i < 4; i++)
      set_param(i, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 31)),
                int'($urandom_range(0, 255)) - 128);
    load_table(4);
    @(negedge clk);
    ch_restart = 1'b1;
    sent = 0; cyc = 0; chan_m = 0; prev_stall = 1'b0; prev_d = 0; prev_ch = 0;
    while ((sent < 1000 || exp_d_q.size() > 0) && cyc < 20000) begin
      @(negedge clk);
      ch_restart = 1'b0;
      a       = int'($urandom_range(0, 2097151)) - 1048576;
      s_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
      s_acc   = a;
      m_ready = $urandom_range(0, 1) == 1;
      #1;
      if (prev_stall) begin
        check("stall_m_valid_held", m_valid, 1);
        check("stall_data_held", m_data, prev_d);
        check("stall_channel_held", m_channel, prev_ch);
      end
      if (m_valid && !m_ready) check("stall_s_ready_low", s_ready, 0);
      if (m_valid && m_ready) begin
        if (exp_d_q.size() == 0) check("rand_unexpected_beat", 1, 0);
        else begin
          check("rand_data", m_data, exp_d_q.pop_front());
          check("rand_channel", m_channel, exp_ch_q.pop_front());
        end
      end
      if (s_valid && s_ready) begin
        exp_d_q.push_back(ref_requant(a, chan_m));
        exp_ch_q.push_back(chan_m);
        chan_m = (chan_m + 1) % 4;
        sent++;
      end
      prev_stall = m_valid && !m_ready;
      prev_d     = m_data;
      prev_ch    = m_channel;
      cyc++;
    end
    s_valid = 1'b0;
    check("rand_all_sent", sent, 1000);
    check("rand_drained", exp_d_q.size(), 0);

    // Table reload with two beats in flight
    exp0 = ref_requant(1000, 0);
    exp1 = ref_requant(-3000, 1);
    @(negedge clk);
    m_ready = 1'b1;
    ch_restart = 1'b1;
    @(negedge clk);
    ch_restart = 1'b0;
    s_valid = 1'b1;
    s_acc = 1000;
    #1 check("inflight_accept0", s_ready, 1);
    @(negedge clk);
    s_acc = -3000;
    #1 check("inflight_accept1", s_ready, 1);
    @(negedge clk);
    s_valid      = 1'b0;
    load_params  = 1'b1;
    num_channels = 8'd2;
    param_valid  = 1'b1;
    mult_in      = 16'd1;
    shift_in     = 5'd0;
    zp_in        = 8'd99;
    set_param(0, 1, 0, 30);
    set_param(1, 1, 0, 40);
    @(negedge clk);
    load_params = 1'b0;
    zp_in = 8'd30;
    #1;
    check("reload_s_ready_low0", s_ready, 0);
    check("reload_params_loaded_low", params_loaded, 0);
    check("inflight0_valid", m_valid, 1);
    check("inflight0_data", m_data, exp0);
    check("inflight0_channel", m_channel, 0);
    @(negedge clk);
    zp_in = 8'd40;
    #1;
    check("reload_s_ready_low1", s_ready, 0);
    check("inflight1_valid", m_valid, 1);
    check("inflight1_data", m_data, exp1);
    check("inflight1_channel", m_channel, 1);
    @(negedge clk);
    param_valid = 1'b0;
    ch_restart  = 1'b1;
    #1;
    check("reload_done_params_loaded", params_loaded, 1);
    check("reload_done_s_ready", s_ready, 1);
    check("reload_drained", m_valid, 0);
    send_one("new_ch0", 0, 30, 0);
    send_one("new_ch1", 0, 40, 1);

    // Reset mid-operation with a stalled output
    @(negedge clk);
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_acc   = 5;
    repeat (3) @(negedge clk);
    rst     = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_params_loaded", params_loaded, 0);
    check("midrst_s_ready", s_ready, 0);
    check("midrst_m_data", m_data, 0);
    check("midrst_m_channel", m_channel, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
